// File: rtl/pipe_pkg.sv
// Shared types and limits for the pipeline hazard/syscall controller.
package pipe_pkg;

  typedef enum logic [1:0] {IDLE, DRAIN, CALL, WAIT} sysState_t;

  localparam int MIN_STAGES    = 3;
  localparam int MAX_STAGES    = 8;
  localparam int DEFAULT_CNT_W = 32;
  // Drain counter must hold up to MAX_STAGES-2.
  localparam int DRAIN_W       = $clog2(MAX_STAGES - 1);

  function automatic bit stagesLegal(input int n);
    return (n >= MIN_STAGES) && (n <= MAX_STAGES);
  endfunction

endpackage

// File: rtl/pipe_prio.sv
// Highest-set-bit priority encoder: idx is the oldest requesting stage.
module pipe_prio #(
  parameter int WIDTH = 5,
  parameter int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] reqVec,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (reqVec[i]) begin
        idx   = IDX_W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush resolution plus syscall drain-and-call sequencer.
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int NUM_STAGES = 5,
  parameter int CNT_W      = DEFAULT_CNT_W
) (
  input  logic                  CLOCK,
  input  logic                  RESET,
  input  logic [NUM_STAGES-1:0] StallReq_IN,
  input  logic [NUM_STAGES-1:0] FlushReq_IN,
  input  logic                  Syscall_IN,
  input  logic                  SysAck_IN,
  output logic                  StallPC_OUT,
  output logic [NUM_STAGES-2:0] STALL_OUT,
  output logic [NUM_STAGES-2:0] FLUSH_OUT,
  output logic                  Syscall_OUT,
  output logic [CNT_W-1:0]      StallCount_OUT
);

  localparam int IDX_W = $clog2(NUM_STAGES);
  localparam int NR    = NUM_STAGES - 1;
  localparam logic [IDX_W-1:0]   IDX_1      = IDX_W'(1);
  localparam logic [IDX_W-1:0]   IDX_2      = IDX_W'(2);
  localparam logic [NR-1:0]      R0_BIT     = NR'(1);
  localparam logic [NR-1:0]      R1_BIT     = NR'(2);
  localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(NUM_STAGES - 2);

  if (!stagesLegal(NUM_STAGES)) begin : gIllegalStages
    $error("pipe_ctrl: NUM_STAGES out of range");
  end

  logic [IDX_W-1:0]   stallIdx, flushIdx;
  logic               stallValid, flushValid;
  logic               flushApplied, stallActive;
  logic               frontBlocked, decodeKilled, backStall;
  logic [NR-1:0]      normStall, normFlush, stallVec, flushVec;
  logic               holdFront, drainFlush, stallPcInt;
  sysState_t          stateReg, stateNext;
  logic [DRAIN_W-1:0] drainCntReg, drainCntNext;
  logic [CNT_W-1:0]   stallCountReg;

  pipe_prio #(.WIDTH(NUM_STAGES), .IDX_W(IDX_W)) uStallPrio (
    .reqVec(StallReq_IN), .idx(stallIdx), .valid(stallValid)
  );

  pipe_prio #(.WIDTH(NUM_STAGES), .IDX_W(IDX_W)) uFlushPrio (
    .reqVec(FlushReq_IN), .idx(flushIdx), .valid(flushValid)
  );

  // A redirect is dropped when an equal-or-older stage is stalled; otherwise it overrides every younger stall.
  assign flushApplied = flushValid && !(stallValid && (stallIdx >= flushIdx));
  assign stallActive  = stallValid && !flushApplied;
  assign frontBlocked = stallActive && (stallIdx >= IDX_1);
  assign decodeKilled = flushApplied && (flushIdx >= IDX_2);
  assign backStall    = stallValid && (stallIdx >= IDX_2);

  for (genvar gi = 0; gi < NR; gi++) begin : gRegMask
    assign normStall[gi] = stallActive && (IDX_W'(gi) < stallIdx);
    assign normFlush[gi] = (flushApplied && (IDX_W'(gi) < flushIdx)) ||
                           (stallActive && (stallIdx == IDX_W'(gi)));
  end

  always_comb begin
    stateNext    = stateReg;
    drainCntNext = drainCntReg;
    holdFront    = 1'b0;
    drainFlush   = 1'b0;
    case (stateReg)
      IDLE: begin
        if (Syscall_IN && !frontBlocked && !decodeKilled) begin
          stateNext    = DRAIN;
          drainCntNext = DRAIN_LOAD;
          drainFlush   = 1'b1;
        end
      end
      DRAIN: begin
        if (decodeKilled) begin
          stateNext    = IDLE;
          drainCntNext = '0;
        end else begin
          holdFront  = 1'b1;
          drainFlush = 1'b1;
          if (!backStall) begin
            drainCntNext = drainCntReg - 1'b1;
            if (drainCntReg == DRAIN_W'(1)) stateNext = CALL;
          end
        end
      end
      CALL: begin
        holdFront = 1'b1;
        stateNext = WAIT;
      end
      WAIT: begin
        holdFront = 1'b1;
        if (SysAck_IN) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      stateReg    <= IDLE;
      drainCntReg <= '0;
    end else begin
      stateReg    <= stateNext;
      drainCntReg <= drainCntNext;
    end
  end

  assign flushVec   = normFlush | (drainFlush ? R1_BIT : '0);
  assign stallVec   = (normStall | (holdFront ? R0_BIT : '0)) & ~flushVec;
  assign stallPcInt = stallActive | holdFront;

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      stallCountReg <= '0;
    end else if (stallPcInt && (stallCountReg != {CNT_W{1'b1}})) begin
      stallCountReg <= stallCountReg + 1'b1;
    end
  end

  // Combinational outputs are gated so reset silences them without waiting for a clock.
  assign StallPC_OUT    = RESET && stallPcInt;
  assign STALL_OUT      = RESET ? stallVec : '0;
  assign FLUSH_OUT      = RESET ? flushVec : '0;
  assign Syscall_OUT    = RESET && (stateReg == CALL);
  assign StallCount_OUT = stallCountReg;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl with NUM_STAGES=5 (plus a CNT_W=4 copy for saturation).
module tb_pipe_ctrl;

  logic        clk;
  logic        rstN;
  logic [4:0]  stallReq, flushReq;
  logic        syscallIn, sysAck;

  logic        stallPc, syscallOut;
  logic [3:0]  stallOut, flushOut;
  logic [31:0] stallCount;

  logic        stallPc4, syscallOut4;
  logic [3:0]  stallOut4, flushOut4;
  logic [3:0]  stallCount4;

  int nAsserts = 0;
  int nFail    = 0;

  pipe_ctrl #(.NUM_STAGES(5)) dut (
    .CLOCK(clk), .RESET(rstN), .StallReq_IN(stallReq), .FlushReq_IN(flushReq),
    .Syscall_IN(syscallIn), .SysAck_IN(sysAck), .StallPC_OUT(stallPc),
    .STALL_OUT(stallOut), .FLUSH_OUT(flushOut), .Syscall_OUT(syscallOut),
    .StallCount_OUT(stallCount)
  );

  pipe_ctrl #(.NUM_STAGES(5), .CNT_W(4)) dut4 (
    .CLOCK(clk), .RESET(rstN), .StallReq_IN(stallReq), .FlushReq_IN(flushReq),
    .Syscall_IN(syscallIn), .SysAck_IN(sysAck), .StallPC_OUT(stallPc4),
    .STALL_OUT(stallOut4), .FLUSH_OUT(flushOut4), .Syscall_OUT(syscallOut4),
    .StallCount_OUT(stallCount4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [9:0] outs();
    return {syscallOut, stallPc, stallOut, flushOut};
  endfunction

  function automatic logic [9:0] ex(input bit sys, input bit pc, input logic [3:0] st, input logic [3:0] fl);
    return {sys, pc, st, fl};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clearIn();
    stallReq  = '0;
    flushReq  = '0;
    syscallIn = 1'b0;
    sysAck    = 1'b0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rstN = 1'b0;
    clearIn();
    stallReq = 5'b00100;
    #2;
    check("reset_outs", outs(), ex(0, 0, 4'b0000, 4'b0000));
    check("reset_cnt", stallCount, 0);
    check("reset_cnt4", stallCount4, 0);
    #1 stallReq = '0;
    #9 rstN = 1'b1;
    tick();

    // Stall at stage 2 for three cycles.
    for (int c = 0; c < 3; c++) begin
      stallReq = 5'b00100;
      #2;
      check($sformatf("stall2_c%0d", c), outs(), ex(0, 1, 4'b0011, 4'b0100));
      tick();
    end
    stallReq = '0;
    #1;
    check("cnt_after3", stallCount, 3);
    check("cnt4_after3", stallCount4, 3);

    // Seventeen more stall cycles: 20 total, CNT_W=4 copy saturates.
    for (int c = 0; c < 17; c++) begin
      stallReq = 5'b00100;
      tick();
    end
    stallReq = '0;
    #1;
    check("cnt_after20", stallCount, 20);
    check("cnt4_sat", stallCount4, 15);
    tick();
    check("cnt4_hold_idle", stallCount4, 15);
    stallReq = 5'b10000;
    #1;
    check("stall_wb", outs(), ex(0, 1, 4'b1111, 4'b0000));
    tick();
    tick();
    stallReq = '0;
    #1;
    check("cnt4_hold_stall", stallCount4, 15);
    check("cnt_after22", stallCount, 22);

    // Stall versus flush priority.
    flushReq = 5'b00100; stallReq = 5'b00010;
    #1;
    check("flush2_over_stall1", outs(), ex(0, 0, 4'b0000, 4'b0011));
    tick();
    flushReq = 5'b00010; stallReq = 5'b01000;
    #1;
    check("flush1_ignored", outs(), ex(0, 1, 4'b0111, 4'b1000));
    tick();
    flushReq = 5'b10000; stallReq = '0;
    #1;
    check("flush4_alone", outs(), ex(0, 0, 4'b0000, 4'b1111));
    tick();
    flushReq = 5'b01000; stallReq = 5'b01000;
    #1;
    check("flush3_stall3_eq", outs(), ex(0, 1, 4'b0111, 4'b1000));
    tick();
    flushReq = '0; stallReq = 5'b00001;
    #1;
    check("stall_fetch", outs(), ex(0, 1, 4'b0000, 4'b0001));
    tick();
    clearIn();
    tick();

    // Full syscall: t = request cycle.
    syscallIn = 1'b1;
    #1;
    check("sys_t", outs(), ex(0, 0, 4'b0000, 4'b0010));
    tick();
    check("sys_t1_drain", outs(), ex(0, 1, 4'b0001, 4'b0010));
    tick();
    syscallIn = 1'b0;
    #1;
    check("sys_t2_drain", outs(), ex(0, 1, 4'b0001, 4'b0010));
    tick();
    sysAck = 1'b1;
    #1;
    check("sys_t3_drain", outs(), ex(0, 1, 4'b0001, 4'b0010));
    tick();
    sysAck = 1'b0;
    #1;
    check("sys_t4_call", outs(), ex(1, 1, 4'b0001, 4'b0000));
    tick();
    check("sys_t5_wait", outs(), ex(0, 1, 4'b0001, 4'b0000));
    tick();
    sysAck = 1'b1;
    #1;
    check("sys_t6_wait_ack", outs(), ex(0, 1, 4'b0001, 4'b0000));
    tick();
    sysAck = 1'b0;
    #1;
    check("sys_t7_idle", outs(), ex(0, 0, 4'b0000, 4'b0000));
    tick();

    // Syscall with a stage-2 stall during drain: call is delayed by one cycle.
    syscallIn = 1'b1;
    tick();
    syscallIn = 1'b0;
    tick();
    stallReq = 5'b00100;
    #1;
    check("pause_t2_outs", outs(), ex(0, 1, 4'b0001, 4'b0110));
    tick();
    stallReq = '0;
    tick();
    check("pause_t4_no_call", outs(), ex(0, 1, 4'b0001, 4'b0010));
    tick();
    check("pause_t5_call", outs(), ex(1, 1, 4'b0001, 4'b0000));
    tick();
    sysAck = 1'b1;
    tick();
    sysAck = 1'b0;
    tick();

    // Syscall aborted by a stage-3 redirect.
    syscallIn = 1'b1;
    tick();
    syscallIn = 1'b0;
    tick();
    flushReq = 5'b01000;
    #1;
    check("abort_t2", outs(), ex(0, 0, 4'b0000, 4'b0111));
    tick();
    flushReq = '0;
    #1;
    check("abort_t3_idle", outs(), ex(0, 0, 4'b0000, 4'b0000));
    for (int c = 0; c < 3; c++) begin
      tick();
      check($sformatf("abort_nocall_%0d", c), outs(), ex(0, 0, 4'b0000, 4'b0000));
    end

    // Asynchronous reset while waiting for the acknowledge.
    syscallIn = 1'b1;
    tick();
    syscallIn = 1'b0;
    for (int c = 0; c < 4; c++) tick();
    check("rst_pre_wait", outs(), ex(0, 1, 4'b0001, 4'b0000));
    #1 rstN = 1'b0;
    #1;
    check("rst_async_outs", outs(), ex(0, 0, 4'b0000, 4'b0000));
    check("rst_async_cnt", stallCount, 0);
    check("rst_async_cnt4", stallCount4, 0);
    #2 rstN = 1'b1;
    tick();
    check("rst_release_idle", outs(), ex(0, 0, 4'b0000, 4'b0000));
    sysAck = 1'b1;
    tick();
    sysAck = 1'b0;
    check("rst_no_call", outs(), ex(0, 0, 4'b0000, 4'b0000));
    stallReq = 5'b00010;
    #1;
    check("rst_resume_stall", outs(), ex(0, 1, 4'b0001, 4'b0010));
    tick();
    stallReq = '0;
    #1;
    check("rst_resume_cnt", stallCount, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter NUM_STAGES, default 5, number of pipeline stages (legal 3..8); stage 0 = fetch, stage 1 = decode, stage NUM_STAGES-1 = writeback.
REQ-002 SHALL have parameter CNT_W, default 32, width of the stall-cycle counter.
REQ-003 SHALL have port CLOCK  input  1  sole clock; all state updates on the rising edge.
REQ-004 SHALL have port RESET  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port StallReq_IN  input  NUM_STAGES  bit s = stage s cannot complete this cycle.
REQ-006 SHALL have port FlushReq_IN  input  NUM_STAGES  bit k = stage k redirects; all younger instructions are discarded.
REQ-007 SHALL have port Syscall_IN  input  1  decode stage holds a syscall.
REQ-008 SHALL have port SysAck_IN  input  1  system has finished servicing the syscall.
REQ-009 SHALL have port StallPC_OUT  output  1  PC holds its value.
REQ-010 SHALL have port STALL_OUT  output  NUM_STAGES-1  bit i = pipeline register R_i (between stage i and i+1) holds.
REQ-011 SHALL have port FLUSH_OUT  output  NUM_STAGES-1  bit i = R_i loads a bubble.
REQ-012 SHALL have port Syscall_OUT  output  1  syscall service request to the system.
REQ-013 SHALL have port StallCount_OUT  output  CNT_W  number of cycles with StallPC_OUT high, saturating.

Function
REQ-014 SHALL select s = the highest-numbered (oldest) set bit of StallReq_IN; registers R_0..R_(s-1) and PC SHALL hold; R_s SHALL flush when s < NUM_STAGES-1; older registers SHALL advance.
REQ-015 SHALL select k = the highest set bit of FlushReq_IN, and apply it only if no stall bit at index >= k is set; if applied, R_0..R_(k-1) SHALL flush and STALL_OUT for those bits SHALL be 0.
REQ-016 SHALL resolve a stall with s < k and an applied flush from k in favour of the flush: no hold on PC or on R_0..R_(k-1).
REQ-017 SHALL never assert STALL_OUT[i] and FLUSH_OUT[i] together; flush has priority.
REQ-018 SHALL use FSM states IDLE, DRAIN, CALL, WAIT.
REQ-019 SHALL move from IDLE to DRAIN when Syscall_IN=1 and stage 1 is not stalled; it SHALL load the drain counter with NUM_STAGES-2 and flush R_1, so the syscall itself retires as a bubble.
REQ-020 SHALL, in DRAIN, hold PC and R_0, flush R_1, and decrement the counter each cycle; the transition to CALL SHALL occur when the counter reaches 0.
REQ-021 SHALL, in CALL, assert Syscall_OUT for exactly one cycle and keep PC and R_0 held, then go to WAIT.
REQ-022 SHALL, in WAIT, keep PC and R_0 held until SysAck_IN=1, then go to IDLE; fetch resumes the next cycle.
REQ-023 SHALL pause the drain counter on a stall at any stage >= 2 during DRAIN.
REQ-024 SHALL, on an applied flush from stage k >= 2 during DRAIN, abort to IDLE without asserting Syscall_OUT.
REQ-025 SHALL ignore Syscall_IN outside IDLE; SysAck_IN in IDLE, DRAIN or CALL SHALL have no effect.
REQ-026 SHALL increment StallCount_OUT each cycle StallPC_OUT=1 and saturate at 2^CNT_W-1, with no wrap-around.
REQ-027 SHALL produce STALL_OUT, FLUSH_OUT and StallPC_OUT combinationally from the inputs and state, with zero latency; Syscall_OUT SHALL be decoded from state.

Reset
REQ-028 SHALL, when RESET=0, immediately force state IDLE, drain counter 0, StallCount_OUT 0, Syscall_OUT 0, STALL_OUT 0, FLUSH_OUT 0 and StallPC_OUT 0, regardless of CLOCK.
REQ-029 SHALL discard a syscall in progress when reset asserts mid-DRAIN/CALL/WAIT, with no Syscall_OUT after release.
REQ-030 SHALL resume normal decoding on the first rising edge after RESET returns to 1.

Structure
REQ-031 SHALL take the FSM state enumeration, the NUM_STAGES limits and the default CNT_W from shared package pipe_pkg.
REQ-032 SHALL instantiate one sub-module, pipe_prio (parametrised highest-set-bit priority encoder returning index and valid), once for stalls and once for flushes.
REQ-033 SHALL hold roughly 150-300 lines of RTL in total, with no memories.

Verification (NUM_STAGES=5)
REQ-034 SHALL cover StallReq_IN=00100 for 3 cycles -> StallPC_OUT=1, STALL_OUT=0011, FLUSH_OUT=0100 each cycle; StallCount_OUT=3 afterwards.
REQ-035 SHALL cover FlushReq_IN=00100 with StallReq_IN=00010 -> FLUSH_OUT=0011, STALL_OUT=0000, StallPC_OUT=0; and FlushReq_IN=00010 with StallReq_IN=01000 -> flush ignored, STALL_OUT=0111, FLUSH_OUT=1000.
REQ-036 SHALL cover Syscall_IN pulse at cycle t -> DRAIN for cycles t+1..t+3, Syscall_OUT=1 at t+4 only, PC held until the cycle after SysAck_IN.
REQ-037 SHALL cover syscall followed by FlushReq_IN=01000 at t+2 -> IDLE at t+3, Syscall_OUT never asserted.
REQ-038 SHALL cover RESET pulled low asynchronously in WAIT -> all outputs 0 before the next edge; the state after release is IDLE.
REQ-039 SHALL cover CNT_W=4 with 20 stall cycles -> StallCount_OUT=15, held there.
